serial_sub: RTL
===============

Name: serial_sub

Overview:
- Multi-cycle, bit-serial signed subtractor. The inverse operation to the team's combinational n-bit signed adder.
- Computes D = X - Y one bit per clock, LSB first, using two's-complement addition (X + ~Y + 1).
- Full-precision n+1-bit result, so overflow is impossible.
- Sits in datapaths where area matters more than latency; controlled by a start/busy/done handshake.

Parameters:
- n, default 4, operand width in bits (n >= 2); result width is n+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new subtraction; sampled only when idle.
- X  input  n  signed minuend; sampled on the accepting edge only.
- Y  input  n  signed subtrahend; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; D is valid and updated this cycle.
- D  output  n+1  signed difference; held until the next completion.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, D=0, internal shift registers, carry and counter cleared. Reset has priority over everything else.
- States: IDLE, RUN.
- IDLE + start=1:
  - Latch sign-extended X into shift register A (n+1 bits) and sign-extended ~Y into B (n+1 bits).
  - Set carry c=1 and bit counter k=0.
  - Go to RUN; busy=1 from the next cycle.
- IDLE + start=0: remain IDLE; D holds its value.
- RUN, each edge:
  - Bit d = A[0] ^ B[0] ^ c; carry c = majority(A[0], B[0], c).
  - Shift d into the MSB of result shift register R; shift A and B right by one; k=k+1.
- Completion: on the edge where k reaches n (the n+1-th RUN edge):
  - D <= final R value; done=1 for exactly one cycle.
  - State returns to IDLE; busy=0 in that same cycle.
- Latency: start accepted at edge e; done high in the cycle following edge e+n+1 (n+1 cycles; 5 cycles for n=4).
- Back-to-back: start may be asserted in the done cycle. It is accepted because the FSM is already IDLE, giving a throughput of one result per n+2 cycles.
- start while busy: ignored; X and Y changes while busy: ignored (operands were latched).
- Width/arithmetic: result is exact for all input pairs. Range is -(2^n - 1) to 2^n - 1 (min-max and max-min of n-bit signed operands). The final carry-out is discarded.
- Reset mid-operation: operation aborted, no done pulse, D=0.
- Counter width: $clog2(n+1); wrap-around is not possible because k is cleared on acceptance.

Optional Feature:
- Macro SERIAL_SUB_ZERO_FLAG_EN.
- Defined:
  - Adds output port Z (1 bit), registered alongside D.
  - Z=1 when the newly loaded D equals 0; updated only on the done edge.
  - Reset value 0.
- Undefined: port Z and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_sub_pkg:
  - typedef enum logic {IDLE, RUN} sub_state_t.
  - Helper function for counter width.
- One sub-module, fa_bit: combinational 1-bit full adder (a, b, cin -> s, cout), instantiated once for the serial bit slice.
- Everything else (FSM, shift registers, counter) stays in serial_sub.

Test Plan (n=4):
- Reset, then idle 3 cycles -> busy=0, done=0, D=0, Z=0 (if enabled).
- X=3, Y=5, start pulse -> busy for 5 cycles; done pulse in cycle 5 after acceptance; D=-2 (5'b11110).
- X=-8, Y=7 -> D=-15 (5'b10001). Then X=7, Y=-8 -> D=15 (5'b01111). Both exact, with no overflow.
- X=6, Y=6 -> D=0; with SERIAL_SUB_ZERO_FLAG_EN defined, Z=1. Next op X=1, Y=0 -> D=1, Z=0.
- start held high continuously with X=2, Y=-3 -> a done pulse every 6 cycles with D=5. Changing X mid-operation does not affect the current result.
- Start X=4, Y=1, assert rst on the 3rd RUN cycle -> no done pulse, D=0, busy=0. A fresh start then completes normally with D=3.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial signed subtractor.
package serial_sub_pkg;

  typedef enum logic {IDLE, RUN} sub_state_t;

  // Bits needed for a counter that must hold the values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_sub_fa_bit.sv
// Combinational 1-bit full adder used as the serial arithmetic slice.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial signed subtractor D = X - Y, LSB first, n+1-bit exact result.
// Optional zero flag output Z is enabled by defining SERIAL_SUB_ZERO_FLAG_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int n = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [n-1:0] X,
  input  logic signed [n-1:0] Y,
  output logic                busy,
  output logic                done,
  output logic signed [n:0]   D
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic                Z
`endif
);

  localparam int KW = cnt_width(n);
  localparam logic [KW-1:0] K_LAST = KW'(n);

  sub_state_t    state_q, state_d;
  logic [n:0]    a_q, a_d;
  logic [n:0]    b_q, b_d;
  logic [n:0]    r_q, r_d;
  logic [n:0]    d_q, d_d;
  logic [KW-1:0] k_q, k_d;
  logic          c_q, c_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          z_q, z_d;
  logic          sum_s;
  logic          cout_s;

  fa_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (sum_s),
    .cout (cout_s)
  );

  // Next-state logic; B holds ~Y and the carry starts at 1 to form X + ~Y + 1.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    k_d     = k_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {X[n-1], X};
          b_d     = ~{Y[n-1], Y};
          c_d     = 1'b1;
          k_d     = {KW{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d = {1'b0, a_q[n:1]};
        b_d = {1'b0, b_q[n:1]};
        c_d = cout_s;
        r_d = {sum_s, r_q[n:1]};
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          d_d     = {sum_s, r_q[n:1]};
          z_d     = ({sum_s, r_q[n:1]} == {(n+1){1'b0}});
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {(n+1){1'b0}};
      b_q     <= {(n+1){1'b0}};
      r_q     <= {(n+1){1'b0}};
      d_q     <= {(n+1){1'b0}};
      k_q     <= {KW{1'b0}};
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      k_q     <= k_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      z_q     <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  assign Z = z_q;
`else
  logic unused_z_s;
  assign unused_z_s = z_q;
`endif

endmodule
